// File: rtl/ring_buffer_ctrl.sv
// rtl/ring_buffer_ctrl.sv - ring buffer pointer/count controller for an external memory; optional RING_BUFFER_CTRL_STICKY_OVERFLOW_EN
module ring_buffer_ctrl #(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          push_acc;
    logic          pop_acc;
    logic          push_rej;

    // Wrap at DEPTH-1 explicitly so non-power-of-two depths never reach an out-of-range address
    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + AW'(1);
    endfunction

    assign full  = (cnt == FULL_CNT);
    assign empty = (cnt == '0);

    // A simultaneous pop frees the slot, so a push into a full buffer is still accepted;
    // rst_n gates the strobes so nothing is written while reset is held
    assign push_acc  = push & (~full | pop) & ~clear & rst_n;
    assign pop_acc   = pop & ~empty & ~clear & rst_n;
    assign push_rej  = push & full & ~pop & rst_n;
    assign underflow = pop & empty & rst_n;

    assign wr_en   = push_acc;
    assign wr_addr = wr_ptr;
    assign rd_addr = rd_ptr;
    assign count   = cnt;

    // Pointer and occupancy state; clear flushes ahead of any push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop_acc) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push_acc && !pop_acc) begin
                cnt <= cnt + CW'(1);
            end else if (pop_acc && !push_acc) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

`ifdef RING_BUFFER_CTRL_STICKY_OVERFLOW_EN
    logic overflow_q;

    // Latch any rejected push until software flushes the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (push_rej) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = push_rej;
`endif

endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// tb/tb_ring_buffer_ctrl.sv - self-checking bench for ring_buffer_ctrl at DEPTH 5 and 64
module tb_ring_buffer_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_s [2];
    logic       push_s  [2];
    logic       pop_s   [2];

    logic       wr_en0, full0, empty0, ovf0, unf0;
    logic [2:0] wr_addr0, rd_addr0, count0;
    logic       wr_en1, full1, empty1, ovf1, unf1;
    logic [5:0] wr_addr1, rd_addr1;
    logic [6:0] count1;

    int checks = 0;
    int failures = 0;

    // reference model: running totals of accepted pushes/pops since the last flush
    int dep [2] = '{5, 64};
    int m_wr [2];
    int m_rd [2];
    bit m_sticky [2];

    always #5 clk = ~clk;

    ring_buffer_ctrl #(.DEPTH(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear_s[0]), .push(push_s[0]), .pop(pop_s[0]),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .rd_addr(rd_addr0), .full(full0), .empty(empty0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    ring_buffer_ctrl #(.DEPTH(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear_s[1]), .push(push_s[1]), .pop(pop_s[1]),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .rd_addr(rd_addr1), .full(full1), .empty(empty1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic get_obs(input int s, output int we, output int wa, output int ra,
                           output int fu, output int em, output int cn, output int ov, output int un);
        if (s == 0) begin
            we = int'(wr_en0); wa = int'(wr_addr0); ra = int'(rd_addr0); fu = int'(full0);
            em = int'(empty0); cn = int'(count0); ov = int'(ovf0); un = int'(unf0);
        end else begin
            we = int'(wr_en1); wa = int'(wr_addr1); ra = int'(rd_addr1); fu = int'(full1);
            em = int'(empty1); cn = int'(count1); ov = int'(ovf1); un = int'(unf1);
        end
    endtask

    task automatic check_reset_vals(input int s, input string tag);
        int we, wa, ra, fu, em, cn, ov, un;
        get_obs(s, we, wa, ra, fu, em, cn, ov, un);
        chk({tag, ".wr_en"}, we, 0);
        chk({tag, ".wr_addr"}, wa, 0);
        chk({tag, ".rd_addr"}, ra, 0);
        chk({tag, ".full"}, fu, 0);
        chk({tag, ".empty"}, em, 1);
        chk({tag, ".count"}, cn, 0);
        chk({tag, ".overflow"}, ov, 0);
        chk({tag, ".underflow"}, un, 0);
    endtask

    // One cycle on instance s: drive at the falling edge, check mid-low-phase, model at the rising edge
    task automatic step(input int s, input bit p, input bit q, input bit c);
        int we, wa, ra, fu, em, cn, ov, un;
        int occ, d;
        bit f_e, e_e, pa, qa, rej, ov_e;
        d = dep[s];
        push_s[s] = p; pop_s[s] = q; clear_s[s] = c;
        #2;
        occ = m_wr[s] - m_rd[s];
        f_e = (occ == d);
        e_e = (occ == 0);
        pa  = p && (!f_e || q) && !c;
        qa  = q && !e_e && !c;
        rej = p && f_e && !q;
`ifdef RING_BUFFER_CTRL_STICKY_OVERFLOW_EN
        ov_e = m_sticky[s];
`else
        ov_e = rej;
`endif
        get_obs(s, we, wa, ra, fu, em, cn, ov, un);
        chk($sformatf("d%0d.wr_en", d), we, int'(pa));
        chk($sformatf("d%0d.wr_addr", d), wa, m_wr[s] % d);
        chk($sformatf("d%0d.rd_addr", d), ra, m_rd[s] % d);
        chk($sformatf("d%0d.count", d), cn, occ);
        chk($sformatf("d%0d.full", d), fu, int'(f_e));
        chk($sformatf("d%0d.empty", d), em, int'(e_e));
        chk($sformatf("d%0d.underflow", d), un, int'(q && e_e));
        chk($sformatf("d%0d.overflow", d), ov, int'(ov_e));
        @(posedge clk);
        if (c) begin
            m_wr[s] = 0; m_rd[s] = 0; m_sticky[s] = 1'b0;
        end else begin
            m_wr[s] += int'(pa);
            m_rd[s] += int'(qa);
            if (rej) m_sticky[s] = 1'b1;
        end
        @(negedge clk);
        push_s[s] = 1'b0; pop_s[s] = 1'b0; clear_s[s] = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_wr[i] = 0; m_rd[i] = 0; m_sticky[i] = 1'b0;
        end
    endtask

    initial begin
        int we, wa, ra, fu, em, cn, ov, un;
        for (int i = 0; i < 2; i++) begin
            clear_s[i] = 1'b0; push_s[i] = 1'b1; pop_s[i] = 1'b1;
        end
        model_reset();

        // reset held with push/pop active: strobes must stay quiet
        #12;
        check_reset_vals(0, "rst5");
        check_reset_vals(1, "rst64");
        for (int i = 0; i < 2; i++) begin
            push_s[i] = 1'b0; pop_s[i] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // fill DEPTH=5
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        get_obs(0, we, wa, ra, fu, em, cn, ov, un);
        chk("fill5.count", cn, 5);
        chk("fill5.full", fu, 1);
        chk("fill5.empty", em, 0);

        // push into full: rejected, then idle to see overflow behaviour
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // full with push+pop x3
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        get_obs(0, we, wa, ra, fu, em, cn, ov, un);
        chk("pp3.count", cn, 5);
        chk("pp3.wr_addr", wa, 3);
        chk("pp3.rd_addr", ra, 3);

        // flush, then the wrap sequence
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        get_obs(0, we, wa, ra, fu, em, cn, ov, un);
        chk("wrap5.count", cn, 2);
        chk("wrap5.rd_addr", ra, 3);
        chk("wrap5.wr_addr", wa, 0);

        // empty edge cases
        step(0, 0, 0, 1);
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        get_obs(0, we, wa, ra, fu, em, cn, ov, un);
        chk("epp.count", cn, 1);

        // count=3 then asynchronous reset between edges
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_vals(0, "arst5");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0);

        // DEPTH=64 directed wrap regression
        for (int i = 0; i < 64; i++) step(1, 1, 0, 0);
        get_obs(1, we, wa, ra, fu, em, cn, ov, un);
        chk("fill64.full", fu, 1);
        for (int i = 0; i < 64; i++) step(1, 0, 1, 0);
        for (int i = 0; i < 64; i++) step(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
        get_obs(1, we, wa, ra, fu, em, cn, ov, un);
        chk("wrap64.count", cn, 61);
        chk("wrap64.rd_addr", ra, 3);

        // randomized traffic on both depths
        for (int n = 0; n < 400; n++) begin
            int s;
            bit p, q, c;
            s = (n % 2);
            p = ($urandom_range(0, 99) < 55);
            q = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 99) < 2);
            step(s, p, q, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
